// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain scheduler: register addresses,
// scheduler states and the power-up command ROM.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_DISPTEST  = 4'hF;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_INTENS,
        ST_ROWS
    } sched_state_t;

    typedef logic [15:0] cmd_t;

    localparam int INIT_LEN        = 5;
    localparam int INIT_INTENS_IDX = 3;

    // The data byte of entry INIT_INTENS_IDX is a default of zero; the scheduler
    // replaces it with its INIT_INTENSITY parameter.
    localparam cmd_t INIT_ROM [INIT_LEN] = '{
        {4'h0, REG_DISPTEST,  8'h00},
        {4'h0, REG_DECODE,    8'h00},
        {4'h0, REG_SCANLIM,   8'h07},
        {4'h0, REG_INTENSITY, 8'h00},
        {4'h0, REG_SHUTDOWN,  8'h01}
    };

endpackage

// File: rtl/max7219_word_tx.sv
// Sends one chain-wide SPI word (MSB first, sck idle low) framed by cs,
// then holds cs high for the inter-word gap before pulsing done.
module max7219_word_tx #(
    parameter int N_DEV      = 2,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*N_DEV-1:0]  word,
    output logic                 done,
    output logic                 busy,
    output logic                 sck,
    output logic                 mosi,
    output logic                 cs
);

    localparam int W  = 16 * N_DEV;
    localparam int CW = 16;
    localparam int BW = $clog2(W);
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {TX_IDLE, TX_LEAD, TX_HIGH, TX_LOW, TX_TAIL, TX_GAP} tx_phase_t;

    tx_phase_t      phase;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bits_left;
    logic [W-1:0]   shreg;

    // The current bit sits at the top of the shift register; it only moves on sck falls.
    assign mosi = shreg[W-1];
    assign busy = (phase != TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= TX_IDLE;
            cnt       <= '0;
            bits_left <= '0;
            shreg     <= '0;
            sck       <= 1'b0;
            cs        <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                TX_IDLE: begin
                    if (start) begin
                        cs        <= 1'b0;
                        shreg     <= word;
                        bits_left <= BW'(W - 1);
                        cnt       <= DIV_LOAD;
                        phase     <= TX_LEAD;
                    end
                end
                TX_LEAD, TX_LOW: begin
                    if (cnt == '0) begin
                        sck   <= 1'b1;
                        cnt   <= DIV_LOAD;
                        phase <= TX_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_HIGH: begin
                    if (cnt == '0) begin
                        sck <= 1'b0;
                        cnt <= DIV_LOAD;
                        if (bits_left == '0) begin
                            shreg <= '0;
                            phase <= TX_TAIL;
                        end else begin
                            shreg     <= {shreg[W-2:0], 1'b0};
                            bits_left <= bits_left - 1'b1;
                            phase     <= TX_LOW;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_TAIL: begin
                    if (cnt == '0) begin
                        cs    <= 1'b1;
                        cnt   <= GAP_LOAD;
                        phase <= TX_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_GAP: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        phase <= TX_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: phase <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/max7219_chain_scheduler.sv
// Drives a MAX7219 daisy chain: power-up configuration, then whole frames row by row,
// with intensity updates slotted strictly between frames.
//
// state     | meaning
// ST_INIT   | sending the five power-up commands
// ST_IDLE   | waiting for a frame (or about to service a pending intensity)
// ST_INTENS | sending the latest requested intensity to every device
// ST_ROWS   | streaming rows 0..7 of the latched frame
module max7219_chain_scheduler
    import max7219_pkg::*;
#(
    parameter int         N_DEV          = 2,
    parameter int         CLK_DIV        = 4,
    parameter logic [3:0] INIT_INTENSITY = 4'h8,
    parameter int         GAP_CYCLES     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [64*N_DEV-1:0]  frame,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic                 intensity_we,
    input  logic [3:0]           intensity_in,
    output logic                 init_done,
    output logic                 busy,
    output logic                 sck,
    output logic                 mosi,
    output logic                 cs
);

    localparam int W = 16 * N_DEV;

    sched_state_t         state;
    logic [64*N_DEV-1:0]  frame_buf;
    logic [2:0]           row;
    logic [2:0]           init_idx;
    logic                 pending;
    logic [3:0]           intensity;
    logic                 in_flight;
    logic                 tx_start;
    logic [W-1:0]         tx_word;
    logic                 tx_done;
    logic                 tx_busy;
    cmd_t                 init_cmd;

    function automatic logic [W-1:0] rep_cmd(input cmd_t c);
        return {N_DEV{c}};
    endfunction

    // Highest device lands in the MSBs so it is shifted out first.
    function automatic logic [W-1:0] row_word(input logic [64*N_DEV-1:0] px, input logic [2:0] r);
        logic [W-1:0] w;
        w = '0;
        for (int d = 0; d < N_DEV; d++) begin
            w[16*d +: 16] = {{4'h0, REG_DIGIT0} + {5'd0, r}, px[64*d + 8*r +: 8]};
        end
        return w;
    endfunction

    always_comb begin
        init_cmd = INIT_ROM[init_idx];
        if (init_idx == 3'(INIT_INTENS_IDX)) begin
            init_cmd = {4'h0, REG_INTENSITY, 4'h0, INIT_INTENSITY};
        end
    end

    assign busy = tx_busy | (state == ST_ROWS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            frame_buf   <= '0;
            row         <= '0;
            init_idx    <= '0;
            pending     <= 1'b0;
            intensity   <= INIT_INTENSITY;
            in_flight   <= 1'b0;
            tx_start    <= 1'b0;
            tx_word     <= rep_cmd({4'h0, REG_NOOP, 8'h00});
            frame_ready <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (intensity_we) begin
                pending   <= 1'b1;
                intensity <= intensity_in;
            end
            case (state)
                ST_INIT: begin
                    if (!in_flight) begin
                        tx_start  <= 1'b1;
                        tx_word   <= rep_cmd(init_cmd);
                        in_flight <= 1'b1;
                    end else if (tx_done) begin
                        in_flight <= 1'b0;
                        if (init_idx == 3'(INIT_LEN - 1)) begin
                            state     <= ST_IDLE;
                            init_done <= 1'b1;
                        end else begin
                            init_idx <= init_idx + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    // An advertised ready is always honoured, even if an intensity write races it.
                    if (frame_ready && frame_valid) begin
                        frame_buf   <= frame;
                        row         <= '0;
                        tx_start    <= 1'b1;
                        tx_word     <= row_word(frame, 3'd0);
                        in_flight   <= 1'b1;
                        frame_ready <= 1'b0;
                        state       <= ST_ROWS;
                    end else if (pending) begin
                        frame_ready <= 1'b0;
                        state       <= ST_INTENS;
                    end else begin
                        frame_ready <= !intensity_we;
                    end
                end
                ST_INTENS: begin
                    if (!in_flight) begin
                        tx_start  <= 1'b1;
                        tx_word   <= rep_cmd({4'h0, REG_INTENSITY, 4'h0, intensity});
                        in_flight <= 1'b1;
                        if (!intensity_we) begin
                            pending <= 1'b0;
                        end
                    end else if (tx_done) begin
                        in_flight <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_ROWS: begin
                    if (!in_flight) begin
                        tx_start  <= 1'b1;
                        tx_word   <= row_word(frame_buf, row);
                        in_flight <= 1'b1;
                    end else if (tx_done) begin
                        in_flight <= 1'b0;
                        if (row == 3'd7) begin
                            state <= ST_IDLE;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    max7219_word_tx #(
        .N_DEV      (N_DEV),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_word_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .word  (tx_word),
        .done  (tx_done),
        .busy  (tx_busy),
        .sck   (sck),
        .mosi  (mosi),
        .cs    (cs)
    );

endmodule

// File: tb/tb_max7219_chain_scheduler.sv
// Directed bench for the MAX7219 chain scheduler: decodes the SPI pins back into
// words and checks them, plus the handshake and pin timing, against hand-built values.
module tb_max7219_chain_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] frame = '0;
    logic         frame_valid = 1'b0;
    logic         intensity_we = 1'b0;
    logic [3:0]   intensity_in = 4'h0;
    logic         frame_ready, init_done, busy, sck, mosi, cs;

    int checks = 0;
    int failures = 0;

    logic [31:0] words[$];
    int          word_bits[$];

    always #5 clk = ~clk;

    max7219_chain_scheduler #(
        .N_DEV(2), .CLK_DIV(4), .INIT_INTENSITY(4'h8), .GAP_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .intensity_we(intensity_we), .intensity_in(intensity_in),
        .init_done(init_done), .busy(busy), .sck(sck), .mosi(mosi), .cs(cs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pin monitor: samples on the falling clk edge, away from the active edge.
    logic        prev_sck = 1'b0, prev_cs = 1'b1, mosi_hi = 1'b0;
    int          hi_cnt = 0, lo_cnt = 0, cs_hi = 100, nbits = 0;
    logic [31:0] mon_sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_sck = 1'b0; prev_cs = 1'b1; hi_cnt = 0; lo_cnt = 0;
            cs_hi = 100; nbits = 0; mon_sh = '0;
        end else begin
            if (cs && !prev_cs) begin
                words.push_back(mon_sh);
                word_bits.push_back(nbits);
            end
            if (!cs && prev_cs) begin
                check("cs_gap_ge8", 32'(cs_hi >= 8), 1);
                nbits = 0; mon_sh = '0; lo_cnt = 0;
            end
            cs_hi = cs ? cs_hi + 1 : 0;
            if (sck && !prev_sck) begin
                check("sck_low_4clk", lo_cnt, 4);
                lo_cnt = 0;
                mon_sh = {mon_sh[30:0], mosi};
                nbits++;
                mosi_hi = mosi;
            end
            if (!sck && prev_sck) begin
                check("sck_high_4clk", hi_cnt, 4);
                hi_cnt = 0;
            end
            if (sck) begin
                hi_cnt++;
                if (prev_sck) check("mosi_stable", mosi, mosi_hi);
            end else if (!cs) begin
                lo_cnt++;
            end
            prev_sck = sck;
            prev_cs = cs;
        end
    end

    function automatic logic [127:0] mk_frame(input logic [7:0] base1, input logic [7:0] base0);
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < 8; r++) begin
            f[64 + 8*r +: 8] = base1 + 8'(r);
            f[8*r +: 8]      = base0 + 8'(r);
        end
        return f;
    endfunction

    function automatic logic [31:0] exp_row(input int r, input logic [7:0] b1, input logic [7:0] b0);
        logic [7:0] a;
        a = 8'(r + 1);
        return {a, b1 + 8'(r), a, b0 + 8'(r)};
    endfunction

    task automatic wait_words(input int target, input string tag);
        int n = 0;
        while (words.size() < target && n < 6000) begin @(negedge clk); n++; end
        check(tag, 32'(n < 6000), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!frame_ready && n < 6000) begin @(negedge clk); n++; end
        check(tag, 32'(n < 6000), 1);
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        while (cs && n < 1000) begin @(negedge clk); n++; end
        check(tag, 32'(n < 1000), 1);
    endtask

    task automatic wait_init(input string tag);
        logic [31:0] exp_init [5];
        int n = 0;
        exp_init = '{32'h0F000F00, 32'h09000900, 32'h0B070B07, 32'h0A080A08, 32'h0C010C01};
        while (!init_done && n < 4000) begin @(negedge clk); n++; end
        check({tag, "_init_timeout"}, 32'(n < 4000), 1);
        check({tag, "_ready_at_done"}, frame_ready, 0);
        check({tag, "_init_words"}, words.size(), 5);
        for (int i = 0; i < 5 && i < words.size(); i++) begin
            check($sformatf("%s_init_word%0d", tag, i), words[i], exp_init[i]);
            check($sformatf("%s_init_bits%0d", tag, i), word_bits[i], 32);
        end
        @(negedge clk);
        check({tag, "_ready_after_init"}, frame_ready, 1);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int rises;
        int n;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        wait_init("boot");

        // Frame 1: single row-0 pattern, one-cycle valid pulse
        words.delete();
        frame = '0;
        frame[64 +: 8] = 8'hAA;
        frame[0 +: 8]  = 8'h55;
        frame_valid = 1'b1;
        @(posedge clk); #1 frame_valid = 1'b0;
        @(negedge clk);
        check("f1_ready_low", frame_ready, 0);
        check("f1_busy", busy, 1);
        @(negedge clk);
        check("f1_cs_fall", cs, 0);
        wait_ready("f1_ready_return");
        check("f1_nwords", words.size(), 8);
        check("f1_busy_after", busy, 0);
        for (int r = 0; r < 8 && r < words.size(); r++)
            check($sformatf("f1_row%0d", r), words[r],
                  (r == 0) ? 32'h01AA0155 : {8'(r + 1), 8'h00, 8'(r + 1), 8'h00});

        // Frame 2 with an intensity write during row 4; frame 3 queued right behind it
        words.delete();
        frame = mk_frame(8'h10, 8'h20);
        frame_valid = 1'b1;
        @(posedge clk); #1 frame_valid = 1'b0;
        wait_words(4, "f2_rows0to3");
        wait_cs_low("f2_row4_start");
        intensity_in = 4'h3; intensity_we = 1'b1;
        @(negedge clk);
        intensity_we = 1'b0;
        frame = mk_frame(8'hF0, 8'h80);
        frame_valid = 1'b1;
        wait_ready("f3_ready");
        @(posedge clk); #1 frame_valid = 1'b0;
        check("f3_accept_after_intens", words.size(), 9);

        // Two intensity writes within frame 3: only the last is sent
        wait_words(11, "f3_rows0to2");
        intensity_in = 4'h1; intensity_we = 1'b1;
        @(negedge clk); intensity_we = 1'b0;
        repeat (20) @(negedge clk);
        intensity_in = 4'hF; intensity_we = 1'b1;
        @(negedge clk); intensity_we = 1'b0;
        @(negedge clk);
        check("f3_ready_low_pending", frame_ready, 0);
        wait_ready("f3_done");

        for (int r = 0; r < 8; r++) exp_q.push_back(exp_row(r, 8'h10, 8'h20));
        exp_q.push_back(32'h0A030A03);
        for (int r = 0; r < 8; r++) exp_q.push_back(exp_row(r, 8'hF0, 8'h80));
        exp_q.push_back(32'h0A0F0A0F);
        check("f23_nwords", words.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < words.size(); i++)
            check($sformatf("f23_word%0d", i), words[i], exp_q[i]);

        // Reset in the middle of bit 10 of row 2
        words.delete();
        frame = mk_frame(8'h40, 8'h50);
        frame_valid = 1'b1;
        @(posedge clk); #1 frame_valid = 1'b0;
        wait_words(2, "rst_rows0to1");
        check("rst_row0", words[0], exp_row(0, 8'h40, 8'h50));
        wait_cs_low("rst_row2_start");
        rises = 0; n = 0;
        while (rises < 11 && n < 1000) begin
            @(negedge clk); n++;
            if (sck && !prev_sck) rises++;
        end
        check("rst_bit10_reached", 32'(rises), 11);
        check("rst_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs", cs, 1);
        check("midrst_sck", sck, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", frame_ready, 0);
        check("midrst_init_done", init_done, 0);
        repeat (3) @(negedge clk);
        words.delete();
        rst = 1'b0;
        wait_init("reboot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
